// File: rtl/mac_col_acc_if.sv
// Bus bundle for one systolic MAC column: shared Q/instruction stream in, chained copy and result out.
interface mac_col_acc_if #(
    parameter int bw     = 8,
    parameter int pr     = 8,
    parameter int bw_out = 2*bw+5
) ();
    logic [pr*bw-1:0]  q_in;
    logic [1:0]        i_inst;
    logic              i_signed;
    logic [pr*bw-1:0]  q_out;
    logic [1:0]        o_inst;
    logic [bw_out-1:0] out;
    logic              out_valid;

    modport master (
        output q_in, i_inst, i_signed,
        input  q_out, o_inst, out, out_valid
    );

    modport slave (
        input  q_in, i_inst, i_signed,
        output q_out, o_inst, out, out_valid
    );
endinterface

// File: rtl/mac_col_acc.sv
// Attention MAC column: holds one K vector, pipelines K.Q dot products per chunk and
// accumulates acc_len chunks per output, forwarding q_in/i_inst one cycle later for chaining.
module mac_col_acc #(
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+3,
    parameter int pr      = 8,
    parameter int acc_len = 4,
    parameter int bw_out  = bw_psum+2
) (
    input  logic         clk,
    input  logic         reset,
    mac_col_acc_if.slave bus
);
    localparam int cnt_w = (acc_len > 1) ? $clog2(acc_len) : 1;
    localparam logic [1:0] inst_load  = 2'b01;
    localparam logic [1:0] inst_exec  = 2'b10;
    localparam logic [1:0] inst_clear = 2'b11;

    logic is_load, is_exec, is_clear;
    assign is_load  = (bus.i_inst == inst_load);
    assign is_exec  = (bus.i_inst == inst_exec);
    assign is_clear = (bus.i_inst == inst_clear);

    logic [pr*2*bw-1:0] prod_bus;
    logic               s1_valid_reg, s1_signed_reg;
    logic [bw_psum-1:0] sum_next, s2_sum_reg;
    logic               s2_valid_reg, s2_signed_reg;
    logic [bw_out-1:0]  sum_ext, acc_next, acc_reg, out_reg;
    logic [cnt_w-1:0]   cnt_reg;
    logic               last_chunk, out_valid_reg;
    logic [pr*bw-1:0]   q_out_reg;
    logic [1:0]         o_inst_reg;

    // Stage 1: one K register and one registered product per lane.
    generate
        for (genvar gi = 0; gi < pr; gi++) begin : g_lane
            logic [bw-1:0]          k_reg;
            logic [2*bw-1:0]        prod_reg;
            logic [bw-1:0]          q_lane;
            logic signed [2*bw+1:0] k_wide, q_wide, prod_full;

            assign q_lane    = bus.q_in[gi*bw +: bw];
            assign k_wide    = {{(bw+2){bus.i_signed & k_reg[bw-1]}}, k_reg};
            assign q_wide    = {{(bw+2){bus.i_signed & q_lane[bw-1]}}, q_lane};
            assign prod_full = k_wide * q_wide;
            assign prod_bus[gi*2*bw +: 2*bw] = prod_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    k_reg    <= '0;
                    prod_reg <= '0;
                end else begin
                    if (is_load) k_reg <= q_lane;
                    if (is_exec) prod_reg <= prod_full[2*bw-1:0];
                end
            end
        end
    endgenerate

    // Stage 2: each 2*bw product is widened by the chunk's own signedness before summing.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < pr; i++) begin
            sum_next = sum_next + {{(bw_psum-2*bw){s1_signed_reg & prod_bus[i*2*bw + 2*bw-1]}},
                                   prod_bus[i*2*bw +: 2*bw]};
        end
    end

    assign sum_ext    = {{(bw_out-bw_psum){s2_signed_reg & s2_sum_reg[bw_psum-1]}}, s2_sum_reg};
    assign acc_next   = (cnt_reg == '0) ? sum_ext : acc_reg + sum_ext;
    assign last_chunk = (cnt_reg == cnt_w'(acc_len-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            q_out_reg     <= '0;
            o_inst_reg    <= '0;
            s1_valid_reg  <= 1'b0;
            s1_signed_reg <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_signed_reg <= 1'b0;
            s2_sum_reg    <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            q_out_reg     <= bus.q_in;
            o_inst_reg    <= bus.i_inst;
            s1_valid_reg  <= is_exec;
            s1_signed_reg <= bus.i_signed;
            s2_valid_reg  <= s1_valid_reg & ~is_clear;
            s2_signed_reg <= s1_signed_reg;
            s2_sum_reg    <= sum_next;
            out_valid_reg <= s2_valid_reg & last_chunk;
            if (s2_valid_reg) begin
                acc_reg <= acc_next;
                if (last_chunk) begin
                    out_reg <= acc_next;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + cnt_w'(1);
                end
            end
            // A vector finishing on the clear cycle still publishes; only the running sum is dropped.
            if (is_clear) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end
        end
    end

    assign bus.q_out     = q_out_reg;
    assign bus.o_inst    = o_inst_reg;
    assign bus.out       = out_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_mac_col_acc.sv
// Self-checking bench for mac_col_acc: directed scenarios plus a random run against a
// timed-queue reference model of the chunk dot products and accumulation.
module tb_mac_col_acc;
    localparam int BW      = 8;
    localparam int PR      = 8;
    localparam int ACC_LEN = 4;
    localparam int BW_OUT  = 2*BW+5;
    localparam int QW      = PR*BW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_col_acc_if #(.bw(BW), .pr(PR), .bw_out(BW_OUT)) bus ();
    mac_col_acc #(.bw(BW), .pr(PR), .acc_len(ACC_LEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct { logic rst; logic [1:0] inst; logic [QW-1:0] q; logic sgn; } op_t;
    typedef struct { logic [BW_OUT-1:0] val; int due; } chunk_t;

    int errors = 0;
    int checks = 0;

    // Reference model state: K vector, chunks in flight with the edge at which they accumulate.
    logic [BW-1:0]     m_k [PR];
    chunk_t            pend [$];
    logic [BW_OUT-1:0] m_acc, m_out;
    int                m_cnt;
    logic              m_valid;
    logic [QW-1:0]     m_qout;
    logic [1:0]        m_oinst;
    int                edge_n = 0;

    function automatic logic [QW-1:0] rep(input logic [BW-1:0] b);
        return {PR{b}};
    endfunction

    function automatic logic [QW-1:0] rnd_q();
        logic [QW-1:0] v;
        for (int i = 0; i < QW; i += 32) v[i +: 32] = $urandom;
        return v;
    endfunction

    function automatic op_t mk(input logic rst, input logic [1:0] inst, input logic [QW-1:0] q, input logic sgn);
        op_t o;
        o.rst = rst; o.inst = inst; o.q = q; o.sgn = sgn;
        return o;
    endfunction

    // Plain integer dot product of the model K with q, reduced modulo 2**BW_OUT.
    function automatic logic [BW_OUT-1:0] dot(input logic [QW-1:0] q, input logic sgn);
        longint s, a, b;
        logic [BW-1:0] kb, qb;
        s = 0;
        for (int i = 0; i < PR; i++) begin
            kb = m_k[i];
            qb = q[i*BW +: BW];
            a = sgn ? longint'($signed(kb)) : longint'(kb);
            b = sgn ? longint'($signed(qb)) : longint'(qb);
            s += a * b;
        end
        return s[BW_OUT-1:0];
    endfunction

    task automatic step(input op_t o);
        chunk_t c;
        logic [BW_OUT-1:0] v;
        reset = o.rst; bus.i_inst = o.inst; bus.q_in = o.q; bus.i_signed = o.sgn;
        @(posedge clk);
        if (o.rst) begin
            pend.delete();
            m_acc = '0; m_out = '0; m_cnt = 0; m_valid = 1'b0; m_qout = '0; m_oinst = '0;
            for (int i = 0; i < PR; i++) m_k[i] = '0;
        end else begin
            m_qout = o.q; m_oinst = o.inst; m_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                c = pend.pop_front();
                v = (m_cnt == 0) ? c.val : m_acc + c.val;
                m_acc = v;
                if (m_cnt == ACC_LEN-1) begin m_out = v; m_valid = 1'b1; m_cnt = 0; end
                else m_cnt++;
            end
            if (o.inst == 2'b11) begin pend.delete(); m_acc = '0; m_cnt = 0; end
            if (o.inst == 2'b01) for (int i = 0; i < PR; i++) m_k[i] = o.q[i*BW +: BW];
            if (o.inst == 2'b10) begin c.val = dot(o.q, o.sgn); c.due = edge_n + 2; pend.push_back(c); end
        end
        edge_n++;
        #1;
    endtask

    task automatic test_reset();
        op_t o;
        for (int i = 0; i < 3; i++) begin
            o = mk(1'b1, 2'($urandom_range(0, 3)), rnd_q(), 1'($urandom_range(0, 1)));
            step(o);
            checks++;
            if (bus.q_out !== '0 || bus.o_inst !== 2'b00 || bus.out !== '0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: q_out=%h o_inst=%b out=%0d out_valid=%b, required all zero",
                         i, bus.q_out, bus.o_inst, bus.out, bus.out_valid);
            end
        end
        o = mk(1'b0, 2'b00, rnd_q(), 1'b0);
        step(o);
        checks++;
        if (bus.q_out !== o.q || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: q_out=%h out_valid=%b, required q_out=%h out_valid=0", bus.q_out, bus.out_valid, o.q);
        end
        $display("test_reset done");
    endtask

    task automatic test_unsigned();
        op_t ops[$];
        int pulses = 0, pulse_at = -1, last_exec;
        ops.push_back(mk(1'b0, 2'b01, rep(8'd1), 1'b0));
        repeat (4) ops.push_back(mk(1'b0, 2'b10, rep(8'd2), 1'b0));
        last_exec = ops.size() - 1;
        repeat (5) ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (bus.out_valid !== m_valid || bus.out !== m_out) begin
                errors++;
                $display("FAIL unsigned step %0d: out_valid=%b out=%0d, required out_valid=%b out=%0d", i, bus.out_valid, bus.out, m_valid, m_out);
            end
            if (bus.out_valid === 1'b1) begin pulses++; pulse_at = i; end
        end
        // Pulse is seen after the edge two steps past the last exec step: 3 cycles after presentation.
        checks++;
        if (pulses != 1 || pulse_at != last_exec + 2 || bus.out !== 21'd64) begin
            errors++;
            $display("FAIL unsigned_result: pulses=%0d at step %0d out=%0d, required 1 pulse at step %0d out=64", pulses, pulse_at, bus.out, last_exec + 2);
        end
        $display("test_unsigned done: out=%0d", bus.out);
    endtask

    task automatic test_max_unsigned();
        op_t ops[$];
        int pulses = 0;
        ops.push_back(mk(1'b0, 2'b01, rep(8'd255), 1'b0));
        repeat (4) ops.push_back(mk(1'b0, 2'b10, rep(8'd255), 1'b0));
        repeat (4) ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b1));
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (bus.out_valid !== m_valid || bus.out !== m_out) begin
                errors++;
                $display("FAIL max_unsigned step %0d: out_valid=%b out=%0d, required out_valid=%b out=%0d", i, bus.out_valid, bus.out, m_valid, m_out);
            end
            if (bus.out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || bus.out !== 21'd2080800) begin
            errors++;
            $display("FAIL max_unsigned_result: pulses=%0d out=%0d, required 1 pulse out=2080800", pulses, bus.out);
        end
        $display("test_max_unsigned done: out=%0d", bus.out);
    endtask

    task automatic test_signed();
        op_t ops[$];
        int exp_q[$];
        int pulses = 0, e;
        logic [BW_OUT-1:0] ev;
        ops.push_back(mk(1'b0, 2'b01, rep(8'h80), 1'b0));
        repeat (4) ops.push_back(mk(1'b0, 2'b10, rep(8'h80), 1'b1));
        repeat (3) ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        repeat (4) ops.push_back(mk(1'b0, 2'b10, rep(8'h7f), 1'b1));
        repeat (4) ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        exp_q.push_back(524288);
        exp_q.push_back(-520192);
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (bus.out_valid !== m_valid || bus.out !== m_out) begin
                errors++;
                $display("FAIL signed step %0d: out_valid=%b out=%0d, required out_valid=%b out=%0d", i, bus.out_valid, bus.out, m_valid, m_out);
            end
            if (bus.out_valid === 1'b1) begin
                pulses++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                ev = e[BW_OUT-1:0];
                checks++;
                if (bus.out !== ev) begin
                    errors++;
                    $display("FAIL signed_value pulse %0d: out=%0d, required %0d", pulses, $signed(bus.out), e);
                end
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL signed_pulses: got %0d pulses, required 2", pulses);
        end
        $display("test_signed done: out=%0d", $signed(bus.out));
    endtask

    task automatic test_clear();
        op_t ops[$];
        int pulses = 0;
        // Abandoned partial vector, then a full one.
        repeat (2) ops.push_back(mk(1'b0, 2'b10, rnd_q(), 1'($urandom_range(0, 1))));
        ops.push_back(mk(1'b0, 2'b11, rnd_q(), 1'b0));
        ops.push_back(mk(1'b0, 2'b01, rep(8'd1), 1'b0));
        repeat (4) ops.push_back(mk(1'b0, 2'b10, rep(8'd1), 1'b0));
        repeat (3) ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        // Same again with idle gaps between chunks.
        repeat (2) ops.push_back(mk(1'b0, 2'b10, rnd_q(), 1'b1));
        ops.push_back(mk(1'b0, 2'b11, rnd_q(), 1'b0));
        ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        ops.push_back(mk(1'b0, 2'b10, rep(8'd1), 1'b0));
        ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        ops.push_back(mk(1'b0, 2'b10, rep(8'd1), 1'b1));
        repeat (2) ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        repeat (2) ops.push_back(mk(1'b0, 2'b10, rep(8'd1), 1'b0));
        repeat (3) ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        // Clear landing on the completing cycle must not suppress the result.
        repeat (4) ops.push_back(mk(1'b0, 2'b10, rep(8'd1), 1'b0));
        ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        ops.push_back(mk(1'b0, 2'b11, rnd_q(), 1'b0));
        repeat (3) ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (bus.out_valid !== m_valid || bus.out !== m_out) begin
                errors++;
                $display("FAIL clear step %0d: out_valid=%b out=%0d, required out_valid=%b out=%0d", i, bus.out_valid, bus.out, m_valid, m_out);
            end
            if (bus.out_valid === 1'b1) begin
                pulses++;
                checks++;
                if (bus.out !== 21'd32) begin
                    errors++;
                    $display("FAIL clear_value pulse %0d: out=%0d, required 32", pulses, bus.out);
                end
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL clear_pulses: got %0d pulses, required 3", pulses);
        end
        $display("test_clear done: pulses=%0d", pulses);
    endtask

    task automatic test_reset_midop();
        op_t ops[$];
        int pulses = 0, rst_at;
        ops.push_back(mk(1'b0, 2'b01, rep(8'd1), 1'b0));
        repeat (3) ops.push_back(mk(1'b0, 2'b10, rep(8'd1), 1'b0));
        ops.push_back(mk(1'b1, 2'b10, rnd_q(), 1'b0));
        rst_at = ops.size() - 1;
        repeat (3) ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        ops.push_back(mk(1'b0, 2'b01, rep(8'd2), 1'b0));
        repeat (4) ops.push_back(mk(1'b0, 2'b10, rep(8'd3), 1'b1));
        repeat (4) ops.push_back(mk(1'b0, 2'b00, rnd_q(), 1'b0));
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (bus.out_valid !== m_valid || bus.out !== m_out) begin
                errors++;
                $display("FAIL reset_midop step %0d: out_valid=%b out=%0d, required out_valid=%b out=%0d", i, bus.out_valid, bus.out, m_valid, m_out);
            end
            if (i == rst_at + 3) begin
                checks++;
                if (bus.out !== '0 || pulses != 0) begin
                    errors++;
                    $display("FAIL reset_midop_flush: out=%0d pulses=%0d, required out=0 pulses=0", bus.out, pulses);
                end
            end
            if (bus.out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || bus.out !== 21'd192) begin
            errors++;
            $display("FAIL reset_midop_result: pulses=%0d out=%0d, required 1 pulse out=192", pulses, bus.out);
        end
        $display("test_reset_midop done: out=%0d", bus.out);
    endtask

    task automatic test_random();
        op_t o;
        int r, pulses = 0;
        logic [1:0] inst;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 19);
            inst = (r < 12) ? 2'b10 : (r < 15) ? 2'b01 : (r == 15) ? 2'b11 : 2'b00;
            o = mk(($urandom_range(0, 63) == 0), inst, rnd_q(), 1'($urandom_range(0, 1)));
            step(o);
            checks++;
            if (bus.out_valid !== m_valid || bus.out !== m_out || bus.q_out !== m_qout || bus.o_inst !== m_oinst) begin
                errors++;
                $display("FAIL random step %0d: out_valid=%b out=%h q_out=%h o_inst=%b, required out_valid=%b out=%h q_out=%h o_inst=%b",
                         i, bus.out_valid, bus.out, bus.q_out, bus.o_inst, m_valid, m_out, m_qout, m_oinst);
            end
            if (m_valid) pulses++;
        end
        $display("test_random done: %0d vectors completed", pulses);
    endtask

    initial begin
        bus.q_in = '0; bus.i_inst = 2'b00; bus.i_signed = 1'b0;
        test_reset();
        test_unsigned();
        test_max_unsigned();
        test_signed();
        test_clear();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
